// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the data-memory load/store controller: size codes,
// controller states and byte-lane helpers.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_MERGE = 1'b1
  } lsu_state_t;

  // One bit per byte lane touched by an access of this size at this offset.
  function automatic logic [3:0] lane_mask(input logic [1:0] size,
                                           input logic [1:0] offset);
    logic [3:0] mask;
    mask = 4'b0000;
    case (size)
      SZ_BYTE: mask = 4'b0001 << offset;
      SZ_HALF: mask = offset[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

  // Illegal size or an address that is not naturally aligned for the size.
  function automatic logic req_error(input logic [1:0] size,
                                     input logic [1:0] offset);
    logic err;
    err = 1'b0;
    case (size)
      SZ_BYTE: err = 1'b0;
      SZ_HALF: err = offset[0];
      SZ_WORD: err = (offset != 2'b00);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/dmem_lsu_lane_align.sv
// Byte-lane steering: extracts and extends load data from a RAM word, and
// merges right-justified store data into a RAM word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        sign_ext,
  input  logic [31:0] word_in,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [31:0] shifted;
  logic [3:0]  mask;
  logic [31:0] bit_mask;
  logic [31:0] replicated;

  // Shift the addressed lane down, extend it, and build the store merge.
  always_comb begin
    shifted = word_in >> {offset, 3'b000};
    load_data = 32'h0;
    case (size)
      SZ_BYTE: load_data = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_data = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
      SZ_WORD: load_data = shifted;
      default: load_data = 32'h0;
    endcase

    mask = lane_mask(size, offset);
    bit_mask = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};

    replicated = wdata;
    case (size)
      SZ_BYTE: replicated = {4{wdata[7:0]}};
      SZ_HALF: replicated = {2{wdata[15:0]}};
      default: replicated = wdata;
    endcase

    merged = (word_in & ~bit_mask) | (replicated & bit_mask);
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store controller between the MEM stage and a word-wide data RAM.
// Sub-word stores are a read cycle followed by a merged write cycle.
module dmem_lsu
  import lsu_pkg::*;
#(
  parameter int IDX_W = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout
);

  lsu_state_t       state;
  logic [IDX_W-1:0] lat_idx;
  logic [1:0]       lat_size;
  logic [1:0]       lat_off;
  logic [15:0]      lat_wdata;
  logic [31:0]      old_word;

  logic             in_merge;
  logic             req_err;
  logic [IDX_W-1:0] req_idx;
  logic [IDX_W-1:0] cur_idx;
  logic [1:0]       al_size;
  logic [1:0]       al_off;
  logic [31:0]      al_word;
  logic [31:0]      al_wdata;
  logic [31:0]      load_data;
  logic [31:0]      merged;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^req_addr[31:IDX_W+2];

  // Decode the incoming request and pick the lane-steering operands.
  always_comb begin
    in_merge = (state == ST_MERGE);
    req_err  = req_error(req_size, req_addr[1:0]);
    req_idx  = req_addr[IDX_W+1:2];
    cur_idx  = in_merge ? lat_idx : req_idx;
    al_size  = in_merge ? lat_size : req_size;
    al_off   = in_merge ? lat_off : req_addr[1:0];
    al_word  = in_merge ? old_word : mem_dout;
    al_wdata = in_merge ? {16'h0, lat_wdata} : req_wdata;
  end

  lsu_lane_align u_align (
    .size      (al_size),
    .offset    (al_off),
    .sign_ext  (req_signed),
    .word_in   (al_word),
    .wdata     (al_wdata),
    .load_data (load_data),
    .merged    (merged)
  );

  // RAM-side controls; writes happen for a legal word store or a merge cycle.
  always_comb begin
    req_ready = (state == ST_IDLE);
    mem_addr  = {{(32-IDX_W){1'b0}}, cur_idx};
    mem_din   = merged;
    mem_we    = 1'b0;
    if (!rst) begin
      if (in_merge)
        mem_we = 1'b1;
      else if (req_valid && req_write && !req_err && (req_size == SZ_WORD))
        mem_we = 1'b1;
    end
  end

  // Controller state, read-modify-write latches and registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      lat_idx   <= '0;
      lat_size  <= SZ_BYTE;
      lat_off   <= 2'b00;
      lat_wdata <= 16'h0;
      old_word  <= 32'h0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            if (req_err) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'h0;
            end else if (!req_write) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_rdata <= load_data;
            end else if (req_size == SZ_WORD) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_rdata <= 32'h0;
            end else begin
              lat_idx   <= req_idx;
              lat_size  <= req_size;
              lat_off   <= req_addr[1:0];
              lat_wdata <= req_wdata[15:0];
              old_word  <= mem_dout;
              state     <= ST_MERGE;
            end
          end
        end
        ST_MERGE: begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= 32'h0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
